bus_slave_mem: RTL and testbench

//  AZPR bus responder (slave end) fronting a synchronous single-port word RAM.

---
 rtl/bus_slave_mem_pkg.sv | 19 +
 rtl/bus_slave_mem.sv | 90 +++++++++
 tb/tb_bus_slave_mem.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_mem_pkg.sv
// rtl/bus_slave_mem_pkg.sv - shared bus constants and slave FSM state encoding
package bus_slave_mem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - bus responder with programmable wait states fronting a 1-cycle word RAM
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             rw_q;
  logic             in_range_q;
  logic             accept;
  logic             in_range;

  assign accept   = (state == ST_IDLE) && !cs_ && !as_;
  assign in_range = ({{(32-ADDR_W){1'b0}}, addr} < DEPTH_U);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rw_q        <= READ;
      in_range_q  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt         <= WAIT_LOAD;
        rw_q        <= rw;
        in_range_q  <= in_range;
        mem_addr    <= addr;
        mem_wr_data <= wr_data;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Outputs depend only on registered state so they cannot glitch with bus inputs.
  always_comb begin
    state_d = state;
    rdy_    = DISABLE_;
    rd_data = '0;
    busy    = (state != ST_IDLE);
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        if (cnt == '0) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_en  = in_range_q;
        mem_we  = in_range_q && (rw_q == WRITE);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rdy_ = ENABLE_;
        if (in_range_q && rw_q == READ) rd_data = mem_rd_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb/tb_bus_slave_mem.sv - random bus traffic against a scoreboard for WAIT_CYCLES 0 and 3
module tb_bus_slave_mem;

  localparam int AW = 11;
  localparam int DEPTH = 1024;
  localparam int WIN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n [2];
  logic          cs_, as_, rw;
  logic [AW-1:0] addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data [2];
  logic          rdy_ [2];
  logic          busy [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0]   mem_wr_data [2];
  logic [31:0]   mem_rd_data [2];

  logic [31:0] ram0 [DEPTH];
  logic [31:0] ram3 [DEPTH];
  logic [31:0] sb [DEPTH];

  int checks = 0;
  int errors = 0;

  bus_slave_mem #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset_n[0]), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[0]), .rdy_(rdy_[0]), .busy(busy[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wr_data(mem_wr_data[0]), .mem_rd_data(mem_rd_data[0]));

  bus_slave_mem #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset_n[1]), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[1]), .rdy_(rdy_[1]), .busy(busy[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wr_data(mem_wr_data[1]), .mem_rd_data(mem_rd_data[1]));

  always @(posedge clk) begin
    if (mem_en[0]) begin
      if (mem_we[0]) ram0[mem_addr[0][9:0]] <= mem_wr_data[0];
      mem_rd_data[0] <= ram0[mem_addr[0][9:0]];
    end
    if (mem_en[1]) begin
      if (mem_we[1]) ram3[mem_addr[1][9:0]] <= mem_wr_data[1];
      mem_rd_data[1] <= ram3[mem_addr[1][9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // One bus access observed over a fixed window; dup_k injects a stray as_,
  // rst_k[i] pulls that instance's reset low during cycle k of the window.
  task automatic run_access(input logic csn, input logic r, input logic [AW-1:0] a,
                            input logic [31:0] d, input int dup_k, input int rst_k0,
                            input int rst_k3, input string name);
    int rdy_n [2], rdy_k [2], busy_n [2], en_n [2], we_n [2];
    int rst_k [2];
    logic [31:0] rdv [2];
    logic leak [2];
    logic in_rng;
    rst_k[0] = rst_k0;
    rst_k[1] = rst_k3;
    in_rng = (a < DEPTH);
    for (int i = 0; i < 2; i++) begin
      rdy_n[i] = 0; rdy_k[i] = -1; busy_n[i] = 0; en_n[i] = 0; we_n[i] = 0;
      rdv[i] = '0; leak[i] = 1'b0;
    end
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        cs_ = csn; as_ = 1'b0; rw = r; addr = a; wr_data = d;
      end else if (k == dup_k) begin
        cs_ = 1'b0; as_ = 1'b0; rw = ~r; addr = a ^ 11'h001; wr_data = ~d;
      end else begin
        cs_ = 1'b1; as_ = 1'b1; rw = $urandom_range(0, 1); addr = AW'($urandom); wr_data = $urandom;
      end
      for (int i = 0; i < 2; i++) reset_n[i] = (k == rst_k[i]) ? 1'b0 : 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rdy_[i]) begin
          rdy_n[i]++; rdy_k[i] = k; rdv[i] = rd_data[i];
        end else if (rd_data[i] != 0) leak[i] = 1'b1;
        if (busy[i]) busy_n[i]++;
        if (mem_en[i]) en_n[i]++;
        if (mem_we[i]) we_n[i]++;
        if (rst_k[i] >= 0 && k == rst_k[i] + 1) begin
          check($sformatf("%s_w%0d_rst_outs", name, wait_of(i)),
                {29'd0, rdy_[i], busy[i], mem_en[i]}, 32'd4);
          check($sformatf("%s_w%0d_rst_maddr", name, wait_of(i)), 32'(mem_addr[i]), 32'd0);
          check($sformatf("%s_w%0d_rst_mwd", name, wait_of(i)), mem_wr_data[i], 32'd0);
          check($sformatf("%s_w%0d_rst_rd", name, wait_of(i)), rd_data[i], 32'd0);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      string t;
      logic live;
      t = $sformatf("%s_w%0d", name, wait_of(i));
      live = !csn && rst_k[i] < 0;
      check({t, "_rdy_count"}, 32'(rdy_n[i]), live ? 32'd1 : 32'd0);
      check({t, "_mem_en"}, 32'(en_n[i]), (live && in_rng) ? 32'd1 : 32'd0);
      check({t, "_mem_we"}, 32'(we_n[i]), (live && in_rng && !r) ? 32'd1 : 32'd0);
      check({t, "_rd_idle_zero"}, 32'(leak[i]), 32'd0);
      if (live) begin
        check({t, "_latency"}, 32'(rdy_k[i]), 32'(2 + wait_of(i)));
        check({t, "_busy_cycles"}, 32'(busy_n[i]), 32'(2 + wait_of(i)));
        check({t, "_rd_data"}, rdv[i], (in_rng && r) ? sb[a[9:0]] : 32'd0);
      end else if (rst_k[i] < 0) begin
        check({t, "_busy_cycles"}, 32'(busy_n[i]), 32'd0);
      end
    end
    if (!csn && rst_k0 < 0 && rst_k3 < 0 && in_rng && !r) sb[a[9:0]] = d;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [31:0] rdat;
    for (int j = 0; j < DEPTH; j++) begin
      ram0[j] = '0; ram3[j] = '0; sb[j] = '0;
    end
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    reset_n[0] = 1'b0; reset_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_w%0d_outs", wait_of(i)),
            {27'd0, rdy_[i], busy[i], mem_en[i], mem_we[i], 1'b0}, 32'd16);
      check($sformatf("reset_w%0d_rd", wait_of(i)), rd_data[i], 32'd0);
      check($sformatf("reset_w%0d_maddr", wait_of(i)), 32'(mem_addr[i]), 32'd0);
      check($sformatf("reset_w%0d_mwd", wait_of(i)), mem_wr_data[i], 32'd0);
    end
    @(posedge clk);
    #1;
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    run_access(1'b0, 1'b0, 11'h005, 32'hDEADBEEF, -1, -1, -1, "wr5");
    run_access(1'b0, 1'b1, 11'h005, 32'h0, -1, -1, -1, "rd5");
    run_access(1'b0, 1'b1, 11'h400, 32'h0, -1, -1, -1, "oor_rd");
    run_access(1'b0, 1'b0, 11'h400, 32'h12345678, -1, -1, -1, "oor_wr");
    run_access(1'b0, 1'b1, 11'h000, 32'h0, -1, -1, -1, "rd0_after_oor");
    run_access(1'b0, 1'b1, 11'h7FF, 32'h0, -1, -1, -1, "oor_rd_top");
    run_access(1'b1, 1'b0, 11'h006, 32'hCAFEF00D, -1, -1, -1, "cs_high");
    run_access(1'b0, 1'b1, 11'h006, 32'h0, -1, -1, -1, "rd6_after_cs");
    run_access(1'b0, 1'b0, 11'h020, 32'hA5A5A5A5, 1, -1, -1, "dup_k1");
    run_access(1'b0, 1'b0, 11'h040, 32'h5A5A5A5A, 2, -1, -1, "dup_k2");
    run_access(1'b0, 1'b1, 11'h020, 32'h0, -1, -1, -1, "rd_dup1");
    run_access(1'b0, 1'b1, 11'h021, 32'h0, -1, -1, -1, "rd_dup1_alias");
    run_access(1'b0, 1'b1, 11'h041, 32'h0, -1, -1, -1, "rd_dup2_alias");
    run_access(1'b0, 1'b0, 11'h010, 32'h11111111, -1, -1, -1, "wr10");
    run_access(1'b0, 1'b0, 11'h010, 32'hBAD0BAD0, -1, 0, 3, "rst_abort");
    run_access(1'b0, 1'b1, 11'h010, 32'h0, -1, -1, -1, "rd10_after_abort");

    for (int n = 0; n < 256; n++) begin
      ra = AW'($urandom_range(0, 1100));
      rdat = $urandom;
      run_access(1'b0, 1'b0, ra, rdat, -1, -1, -1, $sformatf("rnd%0d_wr", n));
      ra = (n % 3 == 0) ? ra : AW'($urandom_range(0, 1100));
      run_access(1'b0, 1'b1, ra, 32'h0, -1, -1, -1, $sformatf("rnd%0d_rd", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
